// File: rtl/k2red_mod_mult_pipe.sv
// ============================================================================
// Module      : k2red_mod_mult_pipe
// Description : Multi-lane pipelined Kyber (q = 3329) modular multiplier using
//               two-step K-RED, valid/ready handshake and a tag sideband.
//               Define MODQ_UNSCALE_EN to add a stage that removes the 2704
//               scale factor, so out_c = a*b mod q.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module k2red_mod_mult_pipe #(
  parameter int LANES = 2,
  parameter int TAG_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [12*LANES-1:0]   in_a,
  input  logic [12*LANES-1:0]   in_b,
  input  logic [TAG_W-1:0]      in_tag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [12*LANES-1:0]   out_c,
  output logic [TAG_W-1:0]      out_tag,
  output logic                  busy
);

`ifdef MODQ_UNSCALE_EN
  localparam int DEPTH = 4;
`else
  localparam int DEPTH = 3;
`endif

  logic             w_adv;
  logic [DEPTH-1:0] r_vld;
  logic [TAG_W-1:0] r_tag [DEPTH];

  // One global enable: the whole pipe moves unless the output is blocked.
  assign w_adv     = ~r_vld[DEPTH-1] | out_ready;
  assign in_ready  = w_adv;
  assign out_valid = r_vld[DEPTH-1];
  assign out_tag   = r_tag[DEPTH-1];
  assign busy      = |r_vld;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld <= '0;
      for (int s = 0; s < DEPTH; s++) r_tag[s] <= '0;
    end else if (w_adv) begin
      r_vld    <= {r_vld[DEPTH-2:0], in_valid};
      r_tag[0] <= in_tag;
      for (int s = 1; s < DEPTH; s++) r_tag[s] <= r_tag[s-1];
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic        [11:0] w_a;
    logic        [11:0] w_b;
    logic        [23:0] r_p;
    logic        [11:0] w_m13;
    logic signed [16:0] w_t;
    logic signed [16:0] r_t;
    logic        [11:0] w_m208;
    logic signed [16:0] w_r;
    logic        [11:0] w_c;
    logic        [11:0] r_c;
    logic        [11:0] w_out;

    assign w_a    = in_a[12*l +: 12];
    assign w_b    = in_b[12*l +: 12];
    assign w_m13  = 12'(r_p[7:0]) * 12'd13;
    assign w_t    = $signed({1'b0, r_p[23:8]}) - $signed({5'd0, w_m13});
    assign w_m208 = 12'(r_t[3:0]) * 12'd208;
    assign w_r    = (r_t >>> 4) - $signed({5'd0, w_m208});

    // r lies in [-3328, 4095], so a single add or subtract of q is enough.
    always_comb begin
      w_c = 12'(w_r);
      if (w_r < 0)
        w_c = 12'(w_r + 17'sd3329);
      else if (w_r >= 17'sd3329)
        w_c = 12'(w_r - 17'sd3329);
    end

    always_ff @(posedge clk) begin
      if (w_adv) begin
        r_p <= 24'(w_a) * 24'(w_b);
        r_t <= w_t;
      end
    end

    always_ff @(posedge clk) begin
      if (rst)
        r_c <= '0;
      else if (w_adv)
        r_c <= w_c;
    end

`ifdef MODQ_UNSCALE_EN
    logic [21:0] w_x;
    logic [34:0] w_xm;
    logic [10:0] w_qe;
    logic [21:0] w_rem;
    logic [11:0] w_u;
    logic [11:0] r_u;

    // Barrett with 5039 = floor(2^24/q): quotient estimate is at most one low.
    assign w_x   = 22'(r_c) * 22'd767;
    assign w_xm  = 35'(w_x) * 35'd5039;
    assign w_qe  = 11'(w_xm >> 24);
    assign w_rem = w_x - 22'(w_qe) * 22'd3329;
    assign w_u   = (w_rem >= 22'd3329) ? 12'(w_rem - 22'd3329) : 12'(w_rem);

    always_ff @(posedge clk) begin
      if (rst)
        r_u <= '0;
      else if (w_adv)
        r_u <= w_u;
    end

    assign w_out = r_u;
`else
    assign w_out = r_c;
`endif

    assign out_c[12*l +: 12] = w_out;
  end

endmodule

`default_nettype wire
